// File: rtl/date_entry.sv
// rtl/date_entry.sv - serial BCD date entry (DDMMYYYY) with commit/reject strobes; option macro DATE_ENTRY_VALIDATE_EN
module date_entry #(
  parameter int YEARRES = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         digit_in,
  input  logic               digit_valid,
  output logic               digit_ready,
  input  logic               abort,
  output logic [2:0]         digit_idx,
  output logic [YEARRES+8:0] date_out,
  output logic               date_ow,
  output logic               entry_err
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_CHECK   = 2'd1,
    S_RESULT  = 2'd2
  } state_e;

  localparam logic [YEARRES+8:0] DATE_RST = {5'd1, 4'd1, {YEARRES{1'b0}}};

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [6:0]         day_q, day_d;
  logic [6:0]         mon_q, mon_d;
  logic [13:0]        year_q, year_d;
  logic               err_q, err_d;
  logic [YEARRES+8:0] date_q, date_d;
  logic               ow_q, ow_d;
  logic               ee_q, ee_d;

  logic               xfer;
  logic               entry_ok;
  logic [31:0]        year_ext;

  assign xfer     = digit_valid && (state_q == S_COLLECT);
  assign year_ext = 32'(year_q);

`ifdef DATE_ENTRY_VALIDATE_EN
  logic [4:0] max_day;

  // Days in the accumulated month; leap test is year[1:0]==0 to match the calendar.
  always_comb begin
    max_day = 5'd31;
    case (mon_q)
      7'd2:                     max_day = (year_q[1:0] == 2'b00) ? 5'd29 : 5'd28;
      7'd4, 7'd6, 7'd9, 7'd11:  max_day = 5'd30;
      default:                  max_day = 5'd31;
    endcase
  end

  assign entry_ok = !err_q
                 && (mon_q >= 7'd1) && (mon_q <= 7'd12)
                 && (year_ext < (32'd1 << YEARRES))
                 && (day_q != 7'd0) && (day_q <= {2'b00, max_day});
`else
  logic unused_fields;

  // Without validation only the truncated low bits of each field are used.
  assign unused_fields = ^{day_q[6:5], mon_q[6:4], err_q, year_ext[31:YEARRES]};
  assign entry_ok      = 1'b1;
`endif

  // Next-state, accumulator and strobe decode; abort overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    day_d   = day_q;
    mon_d   = mon_q;
    year_d  = year_q;
    err_d   = err_q;
    date_d  = date_q;
    ow_d    = 1'b0;
    ee_d    = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (xfer) begin
          idx_d = idx_q + 3'd1;
          if (idx_q < 3'd2) begin
            day_d = 7'(day_q * 7'd10 + 7'(digit_in));
          end else if (idx_q < 3'd4) begin
            mon_d = 7'(mon_q * 7'd10 + 7'(digit_in));
          end else begin
            year_d = 14'(year_q * 14'd10 + 14'(digit_in));
          end
`ifdef DATE_ENTRY_VALIDATE_EN
          if (digit_in > 4'd9) begin
            err_d = 1'b1;
          end
`endif
          if (idx_q == 3'd7) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        state_d = S_RESULT;
        if (entry_ok) begin
          ow_d   = 1'b1;
          date_d = {day_q[4:0], mon_q[3:0], year_ext[YEARRES-1:0]};
        end else begin
          ee_d = 1'b1;
        end
      end
      S_RESULT: begin
        state_d = S_COLLECT;
        day_d   = '0;
        mon_d   = '0;
        year_d  = '0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase

    if (abort) begin
      state_d = S_COLLECT;
      idx_d   = '0;
      day_d   = '0;
      mon_d   = '0;
      year_d  = '0;
      err_d   = 1'b0;
      date_d  = date_q;
      ow_d    = 1'b0;
      ee_d    = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      idx_q   <= '0;
      day_q   <= '0;
      mon_q   <= '0;
      year_q  <= '0;
      err_q   <= 1'b0;
      date_q  <= DATE_RST;
      ow_q    <= 1'b0;
      ee_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      day_q   <= day_d;
      mon_q   <= mon_d;
      year_q  <= year_d;
      err_q   <= err_d;
      date_q  <= date_d;
      ow_q    <= ow_d;
      ee_q    <= ee_d;
    end
  end

  assign digit_ready = (state_q == S_COLLECT);
  assign digit_idx   = idx_q;
  assign date_out    = date_q;
  assign date_ow     = ow_q;
`ifdef DATE_ENTRY_VALIDATE_EN
  assign entry_err   = ee_q;
`else
  assign entry_err   = 1'b0;
  logic unused_ee;
  assign unused_ee   = ee_q;
`endif

endmodule

// File: tb/tb_date_entry.sv
// tb/tb_date_entry.sv - self-checking bench for date_entry (vector table, corner sequences, random entries)
module tb_date_entry;

  localparam int YEARRES = 12;
  localparam logic [20:0] DATE_RST = {5'd1, 4'd1, 12'd0};

`ifdef DATE_ENTRY_VALIDATE_EN
  localparam bit VAL_ON = 1'b1;
`else
  localparam bit VAL_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        digit_ready;
  logic        abort;
  logic [2:0]  digit_idx;
  logic [20:0] date_out;
  logic        date_ow;
  logic        entry_err;

  int checks = 0;
  int errors = 0;
  logic [20:0] cur_date;

  date_entry #(.YEARRES(YEARRES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_in   (digit_in),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .abort      (abort),
    .digit_idx  (digit_idx),
    .date_out   (date_out),
    .date_ow    (date_ow),
    .entry_err  (entry_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] digs;
    bit          ok_on;
    logic [20:0] date;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal fields from the digit string, calendar month lengths.
  task automatic model(input logic [31:0] digs, output bit ok, output logic [20:0] date);
    int d[8];
    int day, mon, year, mdays;
    int mlen[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    bit bcd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d[i] = int'(digs[31-4*i -: 4]);
      if (d[i] > 9) bcd = 1'b0;
    end
    day  = (d[0] * 10 + d[1]) % 128;
    mon  = (d[2] * 10 + d[3]) % 128;
    year = (d[4] * 1000 + d[5] * 100 + d[6] * 10 + d[7]) % 16384;
    date = {5'(day % 32), 4'(mon % 16), 12'(year % 4096)};
    if (!VAL_ON) begin
      ok = 1'b1;
    end else begin
      ok = bcd && mon >= 1 && mon <= 12 && year < 4096;
      if (ok) begin
        mdays = mlen[mon];
        if (mon == 2 && year % 4 == 0) mdays = 29;
        ok = day >= 1 && day <= mdays;
      end
    end
  endtask

  // Sends eight digits back to back and checks the 2-cycle CHECK/RESULT window.
  task automatic run_entry(input string name, input logic [31:0] digs, input bit ok,
                           input logic [20:0] exp_date, input bit hold);
    for (int i = 0; i < 8; i++) begin
      digit_in    = digs[31-4*i -: 4];
      digit_valid = 1'b1;
      chk({name, " ready"}, 32'(digit_ready), 32'd1);
      chk({name, " idx"}, 32'(digit_idx), 32'(i));
      step();
    end
    if (!hold) digit_valid = 1'b0;
    chk({name, " ready_c1"}, 32'(digit_ready), 32'd0);
    chk({name, " idx_c1"}, 32'(digit_idx), 32'd0);
    chk({name, " ow_c1"}, 32'(date_ow), 32'd0);
    step();
    chk({name, " ready_c2"}, 32'(digit_ready), 32'd0);
    chk({name, " ow"}, 32'(date_ow), 32'(ok));
    chk({name, " err"}, 32'(entry_err), 32'(VAL_ON && !ok));
    if (ok) cur_date = exp_date;
    chk({name, " date"}, 32'(date_out), 32'(cur_date));
    step();
    chk({name, " ready_after"}, 32'(digit_ready), 32'd1);
    chk({name, " ow_after"}, 32'(date_ow), 32'd0);
    chk({name, " err_after"}, 32'(entry_err), 32'd0);
    chk({name, " date_hold"}, 32'(date_out), 32'(cur_date));
    digit_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, " ready"}, 32'(digit_ready), 32'd1);
    chk({name, " idx"}, 32'(digit_idx), 32'd0);
    chk({name, " date"}, 32'(date_out), 32'(DATE_RST));
    chk({name, " ow"}, 32'(date_ow), 32'd0);
    chk({name, " err"}, 32'(entry_err), 32'd0);
  endtask

  initial begin
    logic [31:0] digs;
    bit ok;
    logic [20:0] md;
    int day, mon, year;

    vecs[0] = '{32'h29022024, 1'b1, {5'd29, 4'd2,  12'd2024}};
    vecs[1] = '{32'h29022023, 1'b0, {5'd29, 4'd2,  12'd2023}};
    vecs[2] = '{32'h31042023, 1'b0, {5'd31, 4'd4,  12'd2023}};
    vecs[3] = '{32'h01015000, 1'b0, {5'd1,  4'd1,  12'd904}};
    vecs[4] = '{32'h31124095, 1'b1, {5'd31, 4'd12, 12'd4095}};
    vecs[5] = '{32'h00012000, 1'b0, {5'd0,  4'd1,  12'd2000}};
    vecs[6] = '{32'h01132000, 1'b0, {5'd1,  4'd13, 12'd2000}};
    vecs[7] = '{32'h30091999, 1'b1, {5'd30, 4'd9,  12'd1999}};
    vecs[8] = '{32'h28022100, 1'b1, {5'd28, 4'd2,  12'd2100}};

    rst_n = 1'b0; digit_in = '0; digit_valid = 1'b0; abort = 1'b0;
    cur_date = DATE_RST;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_reset_vals("post_reset");

    for (int v = 0; v < 9; v++) begin
      run_entry($sformatf("vec%0d", v), vecs[v].digs, VAL_ON ? vecs[v].ok_on : 1'b1,
                vecs[v].date, 1'b0);
    end

    // Partial entry then abort; the next entry must start from clean accumulators.
    for (int i = 0; i < 3; i++) begin
      digit_in = (i == 0) ? 4'd1 : (i == 1) ? 4'd2 : 4'd0;
      digit_valid = 1'b1;
      step();
    end
    digit_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort idx", 32'(digit_idx), 32'd0);
    chk("abort ready", 32'(digit_ready), 32'd1);
    chk("abort ow", 32'(date_ow), 32'd0);
    run_entry("after_abort", 32'h01012000, 1'b1, {5'd1, 4'd1, 12'd2000}, 1'b0);

    // Non-BCD digit with digit_valid held high through CHECK/RESULT.
    run_entry("non_bcd", 32'h010A2000, !VAL_ON, {5'd1, 4'd10, 12'd2000}, 1'b1);

    // Abort on the edge of the eighth transfer suppresses the result.
    for (int i = 0; i < 7; i++) begin
      digit_in = 4'd1;
      digit_valid = 1'b1;
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    digit_valid = 1'b0;
    chk("abort8 idx", 32'(digit_idx), 32'd0);
    chk("abort8 ready", 32'(digit_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      chk("abort8 ow", 32'(date_ow), 32'd0);
      chk("abort8 err", 32'(entry_err), 32'd0);
      step();
    end
    run_entry("after_abort8", 32'h29022024, 1'b1, {5'd29, 4'd2, 12'd2024}, 1'b0);

    // Asynchronous reset after five digits.
    for (int i = 0; i < 5; i++) begin
      digit_in = 4'd2;
      digit_valid = 1'b1;
      step();
    end
    digit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    cur_date = DATE_RST;
    check_reset_vals("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_entry("after_reset", 32'h15061999, 1'b1, {5'd15, 4'd6, 12'd1999}, 1'b0);

    // Random entries against the reference model.
    for (int n = 0; n < 40; n++) begin
      day  = $urandom_range(0, 32);
      mon  = $urandom_range(0, 13);
      year = (n % 5 == 0) ? $urandom_range(4000, 9999) : $urandom_range(0, 4095);
      if (n % 7 == 3) begin
        mon  = 2;
        year = $urandom_range(0, 1000) * 4 + (n % 2);
        day  = $urandom_range(27, 30);
      end
      digs = {4'(day / 10), 4'(day % 10), 4'(mon / 10), 4'(mon % 10),
              4'(year / 1000), 4'((year / 100) % 10), 4'((year / 10) % 10), 4'(year % 10)};
      if ($urandom_range(0, 9) == 0) begin
        digs[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
      end
      model(digs, ok, md);
      run_entry($sformatf("rand%0d", n), digs, ok, md, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/date_entry.md
# date_entry

Serial BCD date-entry front end for `digital_calendar`. It accepts eight decimal digits one per handshake in the order D D M M Y Y Y Y and converts them to binary. It range-checks the result, then either presents it on the packed `date_in` format with a one-cycle `date_ow` pulse, or flags an entry error. It sits between the keypad/UART digit source and the calendar's date overwrite port.

## Interface
- `YEARRES`, 12: year field width in bits; must match the calendar's `YEARRES`.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `digit_in`  input  4  BCD digit value.
- `digit_valid`  input  1  source has a digit on `digit_in`.
- `digit_ready`  output  1  block can accept a digit this cycle.
- `abort`  input  1  discard partial entry, synchronous.
- `digit_idx`  output  3  index (0..7) of the next digit expected.
- `date_out`  output  YEARRES+9  packed {day[4:0], month[3:0], year[YEARRES-1:0]}; drives calendar `date_in`.
- `date_ow`  output  1  one-cycle commit strobe; drives calendar `date_ow`.
- `entry_err`  output  1  one-cycle reject strobe.

## Operation
- States:
  - COLLECT: `digit_ready`=1.
  - CHECK: `digit_ready`=0.
  - RESULT: `digit_ready`=0; issues the commit or reject.
- A transfer occurs on a rising edge where `digit_valid`=1 and `digit_ready`=1. Digits presented outside that condition are ignored; the source must hold them until the transfer.
- Accumulators update on each transfer as acc = acc*10 + digit:
  - day: 7 bits, digits 0-1.
  - month: 7 bits, digits 2-3.
  - year: 14 bits, digits 4-7.
- `digit_idx` increments per transfer. The transfer at idx 7 moves the block to CHECK, and `digit_idx` returns to 0.
- CHECK computes validity and registers it; the next state is RESULT.
- RESULT, valid entry: `date_out` is loaded with the truncated fields and `date_ow`=1 for exactly this cycle.
- RESULT, invalid entry: `date_out` is unchanged and `entry_err`=1 for this cycle.
- RESULT always returns to COLLECT with accumulators cleared.
- Validity requires all of:
  - every digit ≤ 9;
  - month in 1..12;
  - year < 2^YEARRES;
  - day in 1..maxday, where:
    - Feb: 29 if year[1:0]==00, else 28;
    - Apr, Jun, Sep, Nov: 30;
    - all other months: 31.
- The leap rule is deliberately identical to the calendar's, so any accepted date is one the calendar can roll from.
- A non-BCD digit is still accepted by the handshake; it only poisons the entry, and the rejection is reported at RESULT.
- `abort` in any state: next state COLLECT, `digit_idx`=0, accumulators cleared, error flag cleared, no strobe. `abort` has priority over a simultaneous transfer and over a pending RESULT.

## Timing
- Reset values:
  - state COLLECT, so `digit_ready`=1;
  - `digit_idx`=0;
  - `date_out`={5'd1, 4'd1, YEARRES'd0};
  - `date_ow`=0, `entry_err`=0.
- Latency: 8th digit transferred at edge N. CHECK occupies cycle N..N+1. The strobe is high in the cycle after edge N+1. `digit_ready` is low for exactly 2 cycles.
- `date_out` changes on the same edge that raises `date_ow` and is stable until the next commit.
- All outputs are registered except `digit_ready`, which is decoded from state.
- Back-to-back: a source holding `digit_valid` high transfers one digit per cycle in COLLECT. A new entry's first digit can be accepted the cycle after RESULT.
- Reset asserted mid-entry: immediate return to the reset values, with no strobe.

## Configuration
- `DATE_ENTRY_VALIDATE_EN` defined: full validity check as above.
- `DATE_ENTRY_VALIDATE_EN` undefined:
  - no checks; every completed entry commits;
  - `entry_err` is tied 0;
  - fields are truncated modulo their widths (day 5 bits, month 4 bits, year YEARRES bits);
  - CHECK is still traversed, so latency is unchanged.

## Test plan
- Digits 2,9,0,2,2,0,2,4 at one per cycle → 2 cycles after last transfer, `date_ow`=1 for one cycle and `date_out`={5'd29, 4'd2, 12'd2024}.
- Digits 2,9,0,2,2,0,2,3 (validate on) → `entry_err`=1 for one cycle, `date_ow`=0, `date_out` unchanged. The same with 3,1,0,4,… gives the same reject.
- Digits 0,1,0,1,5,0,0,0 → validate on: `entry_err`. Validate off: commit with year=5000 mod 4096=904.
- Digits 1,2,0 then `abort`, then 0,1,0,1,2,0,0,0 → single commit {1, 1, 2000}; `digit_idx` reads 0 after the abort.
- Digit 0xA as digit 3 with `digit_valid` held high continuously → `digit_ready` low exactly 2 cycles after the 8th transfer, then `entry_err`. `abort` asserted on the 8th-digit edge → no strobe and `digit_idx`=0.
- Assert `rst_n`=0 mid-entry after 5 digits → outputs at reset values immediately. After release, entry 1,5,0,6,1,9,9,9 commits {15, 6, 1999}.
